multi_cycle_control: RTL

Main control unit of the multi-cycle RISC-V CPU: a Moore finite-state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. It is the producer of the 2-bit ALUOp code that the ALU control decodes (00 = add, 01 = subtract/compare, 10 = use funct fields). It also drives every datapath write enable and mux select. Memory steps stall on a `mem_ready` handshake.

---
 rtl/multi_cycle_pkg.sv | 59 +++++
 rtl/control_output_decode.sv | 73 +++++++
 rtl/multi_cycle_control.sv | 89 ++++++++
 3 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its ALU control.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJal      = 4'd9,
    StHalt     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Combinational state -> control-word decode for multi_cycle_control.
// MULTI_CYCLE_CONTROL_JAL_EN enables decoding of the JAL state.
module control_output_decode
  import multi_cycle_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        // ir_write/pc_write are qualified by mem_ready in the top level
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      StDecode: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemAddr: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = MEMTOREG_MDR;
      end
      StMemWrite: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExecute: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = MEMTOREG_ALUOUT;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = SRCA_REGA;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
      StJal: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = MEMTOREG_PC;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_ALUOUT;
      end
`endif
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM of the multi-cycle RISC-V CPU: state register, next state, reset/mem_ready gating.
// MULTI_CYCLE_CONTROL_JAL_EN adds the JAL state; otherwise JAL halts as illegal.
module multi_cycle_control
  import multi_cycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q;
  state_e cur_st;
  ctrl_t  ctrl;
  logic   en;
  logic   fetch_gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:    if (mem_ready) state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= StMemAddr;
            OP_RTYPE:          state_q <= StExecute;
            OP_BRANCH:         state_q <= StBranch;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
            OP_JAL:            state_q <= StJal;
`else
            OP_JAL:            state_q <= StHalt;
`endif
            default:           state_q <= StHalt;
          endcase
        end
        StMemAddr:  state_q <= (opcode == OP_STORE) ? StMemWrite : StMemRead;
        StMemRead:  if (mem_ready) state_q <= StMemWb;
        StMemWrite: if (mem_ready) state_q <= StFetch;
        StExecute:  state_q <= StAluWb;
        StMemWb, StAluWb, StBranch: state_q <= StFetch;
`ifdef MULTI_CYCLE_CONTROL_JAL_EN
        StJal:      state_q <= StFetch;
`endif
        default:    state_q <= StHalt;
      endcase
    end
  end

  // During reset the selects show FETCH values while every enable is masked.
  assign cur_st     = reset ? StFetch : state_q;
  assign en         = ~reset;
  assign fetch_gate = (cur_st != StFetch) | mem_ready;

  control_output_decode u_decode (
    .state_i(cur_st),
    .ctrl_o (ctrl)
  );

  assign PCWrite     = en & ctrl.pc_write & fetch_gate;
  assign IRWrite     = en & ctrl.ir_write & fetch_gate;
  assign PCWriteCond = en & ctrl.pc_write_cond;
  assign MemRead     = en & ctrl.mem_read;
  assign MemWrite    = en & ctrl.mem_write;
  assign RegWrite    = en & ctrl.reg_write;
  assign illegal     = en & ctrl.illegal;
  assign IorD        = ctrl.iord;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign state       = cur_st;

endmodule
